user_input_conditioner: RTL and testbench

- Conditions the raw board push-buttons and switches before they reach the CPU core's 4-bit User_input port.
- Per channel: 2-flop synchroniser, then a counter-based debounce FSM, then one-cycle press/release pulses, then a sticky press-pending flag cleared by a CPU acknowledge.
- Sits directly upstream of the processor top level. Its debounced level output drives User_input unchanged.

---
 rtl/ui_cond_pkg.sv | 16 +
 rtl/user_input_conditioner_if.sv | 32 +++
 rtl/debounce_channel.sv | 99 +++++++++
 rtl/user_input_conditioner.sv | 32 +++
 tb/tb_user_input_conditioner.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/ui_cond_pkg.sv
// Shared definitions for the user-input conditioner: debounce FSM state
// encoding and the board-level default debounce length.
package ui_cond_pkg;

    // Bit 1 of the encoding is the debounced level (S_HIGH and S_FALL).
    typedef enum logic [1:0] {
        S_LOW  = 2'b00,
        S_RISE = 2'b01,
        S_HIGH = 2'b11,
        S_FALL = 2'b10
    } db_state_t;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;
    localparam int unsigned DEFAULT_CNT_W           = 16;

endpackage

// File: rtl/user_input_conditioner_if.sv
// Pin-side and CPU-side signal bundle of the user-input conditioner.
// master: board/CPU side; slave: the conditioner itself.
interface user_input_conditioner_if #(
    parameter int unsigned N_CH = 4
);

    logic [N_CH-1:0] Raw_in;
    logic [N_CH-1:0] Ack;
    logic [N_CH-1:0] User_input;
    logic [N_CH-1:0] Press_pulse;
    logic [N_CH-1:0] Release_pulse;
    logic [N_CH-1:0] Press_pending;

    modport master (
        output Raw_in,
        output Ack,
        input  User_input,
        input  Press_pulse,
        input  Release_pulse,
        input  Press_pending
    );

    modport slave (
        input  Raw_in,
        input  Ack,
        output User_input,
        output Press_pulse,
        output Release_pulse,
        output Press_pending
    );

endinterface

// File: rtl/debounce_channel.sv
// One conditioned input bit: 2-flop synchroniser, counter-based debounce
// FSM, one-cycle press/release pulses and a sticky press-pending flag.
module debounce_channel
    import ui_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    input  logic ack,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic press_pending
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    db_state_t        state;
    db_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             press_nxt;
    logic             release_nxt;

    // Synchroniser, FSM state, counter, pulse and pending-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            state         <= S_LOW;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_pending <= 1'b0;
        end else begin
            s1            <= raw_in;
            s2            <= s1;
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            // A press seen this cycle outranks a simultaneous acknowledge.
            press_pending <= press_pulse | (press_pending & ~ack);
        end
    end

    // Debounce next-state, counter and pulse decode.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = '0;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            S_LOW: begin
                if (s2) begin
                    state_nxt = S_RISE;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            S_RISE: begin
                if (!s2) begin
                    state_nxt = S_LOW;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_HIGH;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_HIGH: begin
                if (!s2) begin
                    state_nxt = S_FALL;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            S_FALL: begin
                if (s2) begin
                    state_nxt = S_HIGH;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = S_LOW;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = S_LOW;
            end
        endcase
    end

    assign level = (state == S_HIGH) || (state == S_FALL);

endmodule

// File: rtl/user_input_conditioner.sv
// Conditions N_CH raw board inputs for the CPU core's User_input port;
// each bit is handled by an independent debounce_channel.
module user_input_conditioner
    import ui_cond_pkg::*;
#(
    parameter int unsigned N_CH            = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEFAULT_CNT_W
) (
    input logic                    Clk,
    input logic                    Rst,
    user_input_conditioner_if.slave bus
);

    // One debounce channel per input bit.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk           (Clk),
            .rst           (Rst),
            .raw_in        (bus.Raw_in[i]),
            .ack           (bus.Ack[i]),
            .level         (bus.User_input[i]),
            .press_pulse   (bus.Press_pulse[i]),
            .release_pulse (bus.Release_pulse[i]),
            .press_pending (bus.Press_pending[i])
        );
    end

endmodule

// File: tb/tb_user_input_conditioner.sv
// Directed bench for user_input_conditioner with DEBOUNCE_CYCLES=4.
module tb_user_input_conditioner;

    localparam int unsigned N_CH = 4;
    localparam int unsigned DB   = 4;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    user_input_conditioner_if #(.N_CH(N_CH)) bus ();

    user_input_conditioner #(
        .N_CH            (N_CH),
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (4)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    // Advance one rising edge, then settle so outputs are sampled off-edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        bus.Raw_in = 4'hF;
        bus.Ack    = 4'h0;
        Rst        = 1'b1;

        // Reset with all pins high: everything held at zero.
        tick();
        tick();
        check("rst_ui",      32'(bus.User_input),    32'h0);
        check("rst_press",   32'(bus.Press_pulse),   32'h0);
        check("rst_release", 32'(bus.Release_pulse), 32'h0);
        check("rst_pending", 32'(bus.Press_pending), 32'h0);

        // Release reset; pins are first sampled at the next edge (edge 1).
        Rst = 1'b0;
        for (int i = 1; i <= 5; i++) tick();
        check("rst_ui_edge5",    32'(bus.User_input),  32'h0);
        check("rst_press_edge5", 32'(bus.Press_pulse), 32'h0);
        tick();
        check("rst_ui_edge6",    32'(bus.User_input),  32'hF);
        check("rst_press_edge6", 32'(bus.Press_pulse), 32'hF);
        tick();
        check("rst_press_edge7", 32'(bus.Press_pulse),   32'h0);
        check("rst_pending_set", 32'(bus.Press_pending), 32'hF);

        // Acknowledge everything, then release all pins.
        bus.Ack = 4'hF;
        tick();
        bus.Ack = 4'h0;
        check("all_ack", 32'(bus.Press_pending), 32'h0);
        bus.Raw_in = 4'h0;
        for (int i = 1; i <= 5; i++) tick();
        check("all_rel_edge5", 32'(bus.User_input), 32'hF);
        tick();
        check("all_rel_ui",    32'(bus.User_input),    32'h0);
        check("all_rel_pulse", 32'(bus.Release_pulse), 32'hF);
        tick();
        check("all_rel_done",  32'(bus.Release_pulse), 32'h0);

        // Clean press on channel 0.
        bus.Raw_in = 4'b0001;
        for (int i = 1; i <= 5; i++) tick();
        check("c0_press_edge5", 32'(bus.User_input), 32'h0);
        tick();
        check("c0_press_ui",    32'(bus.User_input),  32'h1);
        check("c0_press_pulse", 32'(bus.Press_pulse), 32'h1);
        tick();
        check("c0_press_done",  32'(bus.Press_pulse),   32'h0);
        check("c0_pending",     32'(bus.Press_pending), 32'h1);
        check("c0_ui_hold",     32'(bus.User_input),    32'h1);

        // Single-cycle ack clears channel 0's pending flag.
        bus.Ack = 4'b0001;
        tick();
        bus.Ack = 4'b0000;
        check("c0_ack_clear", 32'(bus.Press_pending), 32'h0);
        tick();
        check("c0_ack_idle",  32'(bus.Press_pending), 32'h0);

        // Bounce on channel 1: 2-cycle high/low pulses never qualify.
        begin
            logic [3:0] pat;
            pat = 4'b0101;
            for (int p = 0; p < 4; p++) begin
                bus.Raw_in[1] = pat[p];
                for (int c = 0; c < 2; c++) begin
                    tick();
                    check("c1_bounce_ui",    32'(bus.User_input[1]),    32'h0);
                    check("c1_bounce_press", 32'(bus.Press_pulse[1]),   32'h0);
                    check("c1_bounce_pend",  32'(bus.Press_pending[1]), 32'h0);
                end
            end
            for (int c = 0; c < 8; c++) begin
                tick();
                check("c1_settle_ui",   32'(bus.User_input[1]),    32'h0);
                check("c1_settle_pend", 32'(bus.Press_pending[1]), 32'h0);
            end
        end

        // Release channel 0.
        bus.Raw_in[0] = 1'b0;
        for (int i = 1; i <= 5; i++) tick();
        check("c0_rel_edge5", 32'(bus.User_input[0]),    32'h1);
        check("c0_rel_early", 32'(bus.Release_pulse[0]), 32'h0);
        tick();
        check("c0_rel_ui",    32'(bus.User_input),    32'h0);
        check("c0_rel_pulse", 32'(bus.Release_pulse), 32'h1);
        check("c0_rel_nopress", 32'(bus.Press_pulse), 32'h0);
        tick();
        check("c0_rel_done",  32'(bus.Release_pulse), 32'h0);

        // Ack on channel 2 coincides with its press pulse: set wins.
        bus.Raw_in[2] = 1'b1;
        for (int i = 1; i <= 6; i++) tick();
        check("c2_press_pulse", 32'(bus.Press_pulse), 32'h4);
        bus.Ack[2] = 1'b1;
        tick();
        check("c2_collide_pend", 32'(bus.Press_pending[2]), 32'h1);
        tick();
        bus.Ack[2] = 1'b0;
        check("c2_second_ack", 32'(bus.Press_pending[2]), 32'h0);

        // Reset while channel 3 is mid-debounce (S_RISE, cnt=2).
        bus.Raw_in[3] = 1'b1;
        for (int i = 1; i <= 4; i++) tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check("c3_rst_ui",    32'(bus.User_input[3]),  32'h0);
        check("c3_rst_press", 32'(bus.Press_pulse[3]), 32'h0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("c3_recount_ui",    32'(bus.User_input[3]),  32'h0);
            check("c3_recount_press", 32'(bus.Press_pulse[3]), 32'h0);
        end
        tick();
        check("c3_recount_done",  32'(bus.User_input[3]),  32'h1);
        check("c3_recount_pulse", 32'(bus.Press_pulse[3]), 32'h1);
        check("c3_c2_repress",    32'(bus.User_input),     32'hC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
